fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the pipelined ARM core. Owns the program counter, issues one-at-a-time requests to instruction memory, and presents each fetched instruction and its address to the IF/ID pipeline register. Handles hazard-unit stalls by buffering a returned instruction. Handles taken-branch redirects from execute by squashing in-flight or buffered instructions and emitting NOP bubbles.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: IF/ID not accepting this cycle.
- branch_taken  in  1  execute-stage redirect, single-cycle pulse.
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0.
- imem_req  out  1  request outstanding/being issued.
- imem_addr  out  32  request address; stable while imem_req and not imem_ready.
- imem_ready  in  1  response valid this cycle for the outstanding request.
- imem_rdata  in  32  instruction word, valid when imem_ready.
- instr_out  out  32  instruction to IF/ID; NOP 32'hE1A0_0000 when not valid.
- pc_out  out  32  byte address of instr_out.
- instr_valid  out  1  instr_out is a real fetched instruction.

## Operation
- State registers: pc, state {FETCH, HOLD, DISCARD}, addr_q (issued address), buf_instr (held word).
- Outputs are combinational from state and inputs, so IF/ID sees fetch results in the same cycle.
- Accept condition: instr_valid & !stall & !branch_taken. On accept, pc <= pc+4, modulo 2^32 wrap.
- FETCH
  - imem_req=1, imem_addr=pc, addr_q<=pc.
  - On imem_ready: instr_out=imem_rdata, pc_out=pc, instr_valid=1.
  - If accepted: pc+4, stay FETCH.
  - If stall: buf_instr<=imem_rdata, go HOLD.
- HOLD
  - imem_req=0, instr_out=buf_instr, pc_out=pc, instr_valid=1.
  - On accept: pc+4, go FETCH.
- DISCARD (redirect arrived while a request was outstanding)
  - imem_req=1, imem_addr=addr_q (old address held), instr_valid=0.
  - On imem_ready: data dropped, go FETCH.
- branch_taken has highest priority in every state:
  - pc<=branch_target; instr_valid forced 0 that cycle.
  - FETCH without imem_ready goes to DISCARD.
  - FETCH with imem_ready goes to FETCH; the response is dropped.
  - HOLD goes to FETCH; buf_instr is discarded.
  - DISCARD stays DISCARD; the newest target wins.
- Branch and stall together: the branch wins; stall is ignored for that cycle.
- Whenever instr_valid=0: instr_out=NOP, pc_out=pc.
- At most one outstanding request; no speculation beyond pc.

## Timing
- While reset is high:
  - imem_req=0, instr_valid=0, instr_out=NOP, pc_out=RESET_PC.
  - Next state: pc=RESET_PC, state=FETCH.
- First request: imem_req=1, imem_addr=RESET_PC in the first cycle after reset deasserts.
- Latency: zero cycles from imem_ready to instr_out. Sustained throughput is one instruction per cycle when memory returns imem_ready every cycle.
- Redirect:
  - The cycle after branch_taken, imem_addr=target if no request was outstanding.
  - Otherwise imem_addr=target the cycle after the pending imem_ready.
- Reset mid-request: state is abandoned and the pending response is not waited for. Instruction memory shares the same reset and must not respond to a pre-reset request.
- A stall held across many cycles keeps HOLD outputs constant.

## Structure
- Shared package (core_pkg): NOP_INSTR=32'hE1A0_0000, fetch_state_t enum, default RESET_PC.
- One natural sub-module: fetch_hold_buffer (buf_instr plus its valid bit, load/clear controls). The PC and state machine stay in fetch_unit.

## Test plan
- Reset, zero-wait memory, no stall -> imem_addr 0,4,8,12 on consecutive cycles; pc_out matches; instr_valid=1 every cycle.
- Stall for 3 cycles while imem_ready returns 0xE3A01005 at pc=8 -> instr_out holds 0xE3A01005, pc_out=8 for 3 cycles; imem_req=0; next fetch at 12 after stall drops.
- branch_taken to 0x100 while a 2-cycle-latency request to 0x20 is pending -> instr_valid=0; imem_addr stays 0x20 until ready; response dropped; next imem_addr=0x100.
- branch_taken to 0x40 in the same cycle as imem_ready and stall -> instr_valid=0, no HOLD entry; next cycle imem_addr=0x40.
- Two redirects (0x80 then 0xC0) during one pending request -> the only subsequent fetch is at 0xC0.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000; reset asserted mid-request -> outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core front end: NOP encoding, fetch FSM states, reset PC.
// Latency: n/a (package only).
// Backpressure: n/a.
package core_pkg;

  // MOV r0, r0: the architectural no-op used for pipeline bubbles.
  localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Holds one fetched instruction while IF/ID is stalled.
// Latency: word visible on instr_o the cycle after load_i.
// Backpressure: none; the owner decides when to load or clear.
// Ports: clk/reset (sync, active-high); load_i captures data_i; clear_i drops
//        the held word; instr_o / vld_o present the held word and its valid bit.
module fetch_hold_buffer
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic [31:0] instr_o,
  output logic        vld_o
);

  logic [31:0] buf_q;
  logic        vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= NOP_INSTR;
      vld_q <= 1'b0;
    end else if (load_i) begin
      buf_q <= data_i;
      vld_q <= 1'b1;
    end else if (clear_i) begin
      vld_q <= 1'b0;
    end
  end

  assign instr_o = buf_q;
  assign vld_o   = vld_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single outstanding imem requests, feeds IF/ID.
// Latency: zero cycles from imem_ready to instr_out; one instruction per cycle sustained.
// Backpressure: stall parks a returned word in the hold buffer and stops requesting;
//               branch_taken overrides stall and squashes in-flight/held words.
// Ports: clk/reset (sync, active-high); stall, branch_taken/branch_target from the
//        pipeline; imem_req/imem_addr/imem_ready/imem_rdata to instruction memory;
//        instr_out/pc_out/instr_valid to the IF/ID register.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         buf_load, buf_clear;
  logic [31:0]  buf_instr;
  logic         buf_vld;
  logic [31:0]  target;
  logic [31:0]  pc_inc;

  assign target = word_align(branch_target);
  assign pc_inc = pc_q + 32'd4;

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (imem_rdata),
    .instr_o (buf_instr),
    .vld_o   (buf_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    instr_out   = NOP_INSTR;
    pc_out      = pc_q;
    instr_valid = 1'b0;

    if (reset) begin
      pc_out = RESET_PC;
    end else begin
      unique case (state_q)
        FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          addr_d    = pc_q;
          if (branch_taken) begin
            // A response arriving with the redirect is simply dropped; without
            // one, the old request is still in flight and must be drained.
            pc_d    = target;
            state_d = imem_ready ? FETCH : DISCARD;
          end else if (imem_ready) begin
            instr_valid = 1'b1;
            instr_out   = imem_rdata;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              pc_d = pc_inc;
            end
          end
        end

        HOLD: begin
          if (branch_taken) begin
            pc_d      = target;
            buf_clear = 1'b1;
            state_d   = FETCH;
          end else begin
            instr_valid = buf_vld;
            instr_out   = buf_instr;
            if (!stall) begin
              pc_d      = pc_inc;
              buf_clear = 1'b1;
              state_d   = FETCH;
            end
          end
        end

        DISCARD: begin
          // Keep presenting the squashed address until memory answers it.
          imem_req  = 1'b1;
          imem_addr = addr_q;
          if (branch_taken) begin
            pc_d = target;
          end
          // A redirect coinciding with the drained response still leaves: no
          // further response would ever come for the old request.
          if (imem_ready) begin
            state_d = FETCH;
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule
